// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//
// Purpose:
//   Shares the register file's single write port between two writeback
//   sources. req0 is the in-order ALU path and req1 is the long-latency path
//   (load/mul/div). Contested cycles are arbitrated round-robin over a
//   valid/ready handshake, and the winning write is registered onto the
//   register file write port. A per-register pending scoreboard tells decode
//   which source registers still have a write outstanding, so decode can stall.
//
// Parameters:
//   XLEN    data width of a register write
//   ADDR_W  register address width (2**ADDR_W registers, x0 hardwired zero)
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   reset          synchronous, active-high reset
//   req0_valid     ALU path has a write to commit
//   req0_ready     req0 granted this cycle (combinational)
//   req0_addr      ALU destination register
//   req0_data      ALU result
//   req1_valid     long-latency path has a write to commit
//   req1_ready     req1 granted this cycle (combinational)
//   req1_addr      long-latency destination register
//   req1_data      long-latency result
//   pend_set       issue of a long-latency op, marks pend_set_addr pending
//   pend_set_addr  destination register of that op
//   rs1_addr       decode source 1 query
//   rs2_addr       decode source 2 query
//   rs1_busy       rs1_addr has a pending write (combinational)
//   rs2_busy       rs2_addr has a pending write (combinational)
//   rd_we          register file write enable (registered)
//   rd_addr        register file write address (registered)
//   rd_data        register file write data (registered)

module regfile_wb_arbiter #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [XLEN-1:0]   req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [XLEN-1:0]   req1_data,
  input  logic              pend_set,
  input  logic [ADDR_W-1:0] pend_set_addr,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              rd_we,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [XLEN-1:0]   rd_data
);

  localparam int NREG = 1 << ADDR_W;

  // Source identifiers for the round-robin pointer.
  typedef enum logic {
    SRC_ALU  = 1'b0,
    SRC_LONG = 1'b1
  } src_t;

  src_t              rr_last;
  logic              grant0;
  logic              grant1;
  logic              transfer;
  logic [ADDR_W-1:0] win_addr;
  logic [XLEN-1:0]   win_data;

  // Only registers x1..xN-1 have storage; x0 is never pending.
  logic [NREG-1:1]   pend_q;
  logic [NREG-1:1]   pend_next;
  logic [NREG-1:0]   pend_all;

  // Grant logic. The grants look only at the valids, the round-robin pointer
  // and reset, so ready never depends on a requester's own addr/data. While
  // reset is high nothing is granted, which drops any offered transfer.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      if (req0_valid && req1_valid) begin
        if (rr_last == SRC_LONG) begin
          grant0 = 1'b1;
        end else begin
          grant1 = 1'b1;
        end
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign transfer   = grant0 || grant1;

  // Select the winner's write. The grants are one-hot, so when req1 is not
  // granted, req0's fields are a don't-care default.
  always_comb begin
    win_addr = req0_addr;
    win_data = req0_data;
    if (grant1) begin
      win_addr = req1_addr;
      win_data = req1_data;
    end
  end

  // Round-robin pointer. It records the last granted source so the other
  // source wins the next contested cycle. It resets to the long-latency
  // source, so the first contested cycle after reset goes to the ALU path.
  // Idle cycles leave it unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_last <= SRC_LONG;
    end else if (grant0) begin
      rr_last <= SRC_ALU;
    end else if (grant1) begin
      rr_last <= SRC_LONG;
    end
  end

  // Registered write port. Address and data load on every transfer, including
  // a write to x0, so they always reflect the last accepted write. The enable
  // is raised only for real destinations. With no transfer the enable drops
  // and address/data hold their values.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_we   <= 1'b0;
      rd_addr <= '0;
      rd_data <= '0;
    end else if (transfer) begin
      rd_we   <= (win_addr != '0);
      rd_addr <= win_addr;
      rd_data <= win_data;
    end else begin
      rd_we   <= 1'b0;
    end
  end

  // Scoreboard next state. A bit clears on the edge where the registered
  // write commits to that register. ALU writes go through the same port, so
  // the last writer clears the bit either way. A new pend_set on the same
  // edge wins over the clear, because a newer op still owes that register a
  // value. Re-setting an already pending bit simply keeps it set.
  always_comb begin
    pend_next = pend_q;
    for (int i = 1; i < NREG; i++) begin
      if (pend_set && (pend_set_addr == ADDR_W'(i))) begin
        pend_next[i] = 1'b1;
      end else if (rd_we && (rd_addr == ADDR_W'(i))) begin
        pend_next[i] = 1'b0;
      end
    end
  end

  // Scoreboard register. Reset discards every outstanding mark.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_next;
    end
  end

  // Decode queries. Bit 0 of the full view is tied low so x0 never reports busy.
  assign pend_all = {pend_q, 1'b0};
  assign rs1_busy = pend_all[rs1_addr];
  assign rs2_busy = pend_all[rs2_addr];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
//
// Purpose:
//   Self-checking bench for regfile_wb_arbiter. A table of directed vectors
//   is applied one per clock. For each vector the bench checks the
//   combinational ready/busy outputs before the edge and the registered write
//   port after the edge. Hand-written sequences then cover reset, both at
//   start-up and in the middle of operation.
//
// Ports: none (top-level bench).

module tb_regfile_wb_arbiter;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              reset;
  logic              req0_valid;
  logic              req0_ready;
  logic [ADDR_W-1:0] req0_addr;
  logic [XLEN-1:0]   req0_data;
  logic              req1_valid;
  logic              req1_ready;
  logic [ADDR_W-1:0] req1_addr;
  logic [XLEN-1:0]   req1_data;
  logic              pend_set;
  logic [ADDR_W-1:0] pend_set_addr;
  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic              rs1_busy;
  logic              rs2_busy;
  logic              rd_we;
  logic [ADDR_W-1:0] rd_addr;
  logic [XLEN-1:0]   rd_data;

  int checks;
  int failures;

  regfile_wb_arbiter #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .req0_valid    (req0_valid),
    .req0_ready    (req0_ready),
    .req0_addr     (req0_addr),
    .req0_data     (req0_data),
    .req1_valid    (req1_valid),
    .req1_ready    (req1_ready),
    .req1_addr     (req1_addr),
    .req1_data     (req1_data),
    .pend_set      (pend_set),
    .pend_set_addr (pend_set_addr),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .rs1_busy      (rs1_busy),
    .rs2_busy      (rs2_busy),
    .rd_we         (rd_we),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One vector: the inputs driven for one cycle, the ready/busy values
  // expected before the edge, and the write port expected after the edge.
  typedef struct {
    logic              r0v;
    logic [ADDR_W-1:0] r0a;
    logic [XLEN-1:0]   r0d;
    logic              r1v;
    logic [ADDR_W-1:0] r1a;
    logic [XLEN-1:0]   r1d;
    logic              ps;
    logic [ADDR_W-1:0] psa;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic              e_rdy0;
    logic              e_rdy1;
    logic              e_b1;
    logic              e_b2;
    logic              e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [XLEN-1:0]   e_data;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  // Compares one value and records the result.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drives one vector at the falling edge and checks ready/busy before the
  // rising edge, then checks the registered write port just after it.
  task automatic applyStimulus(input int idx, input vec_t v);
    @(negedge clk);
    req0_valid    = v.r0v;
    req0_addr     = v.r0a;
    req0_data     = v.r0d;
    req1_valid    = v.r1v;
    req1_addr     = v.r1a;
    req1_data     = v.r1d;
    pend_set      = v.ps;
    pend_set_addr = v.psa;
    rs1_addr      = v.rs1;
    rs2_addr      = v.rs2;
    #1;
    checkOutput($sformatf("v%0d req0_ready", idx), 32'(req0_ready), 32'(v.e_rdy0));
    checkOutput($sformatf("v%0d req1_ready", idx), 32'(req1_ready), 32'(v.e_rdy1));
    checkOutput($sformatf("v%0d rs1_busy", idx), 32'(rs1_busy), 32'(v.e_b1));
    checkOutput($sformatf("v%0d rs2_busy", idx), 32'(rs2_busy), 32'(v.e_b2));
    @(posedge clk);
    #1;
    checkOutput($sformatf("v%0d rd_we", idx), 32'(rd_we), 32'(v.e_we));
    checkOutput($sformatf("v%0d rd_addr", idx), 32'(rd_addr), 32'(v.e_addr));
    checkOutput($sformatf("v%0d rd_data", idx), 32'(rd_data), v.e_data);
  endtask

  // Drops every request and decode query.
  task automatic idleInputs();
    req0_valid    = 1'b0;
    req0_addr     = '0;
    req0_data     = '0;
    req1_valid    = 1'b0;
    req1_addr     = '0;
    req1_data     = '0;
    pend_set      = 1'b0;
    pend_set_addr = '0;
    rs1_addr      = '0;
    rs2_addr      = '0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Columns: r0v r0a r0d | r1v r1a r1d | ps psa | rs1 rs2 | rdy0 rdy1 b1 b2 | we addr data
    // The round-robin pointer starts at req1, so contested cycles go 0,1,0,1.
    vecs[0]  = '{1, 1, 32'h11,       1, 2, 32'h22,   0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 32'h11};
    vecs[1]  = '{1, 1, 32'h11,       1, 2, 32'h22,   0, 0, 0, 0, 0, 1, 0, 0, 1, 2, 32'h22};
    vecs[2]  = '{1, 1, 32'h11,       1, 2, 32'h22,   0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 32'h11};
    vecs[3]  = '{1, 1, 32'h11,       1, 2, 32'h22,   0, 0, 0, 0, 0, 1, 0, 0, 1, 2, 32'h22};
    // A lone req0 is granted. Its result appears on the next cycle.
    vecs[4]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0,        0, 0, 0, 0, 1, 0, 0, 0, 1, 5, 32'hDEADBEEF};
    // An x0 write is accepted, but the enable stays low.
    vecs[5]  = '{0, 0, 0,            1, 0, 32'h1234, 0, 0, 5, 0, 0, 1, 0, 0, 0, 0, 32'h1234};
    // Mark x7 pending. When idle, the write port holds its address/data.
    vecs[6]  = '{0, 0, 0,            0, 0, 0,        1, 7, 7, 0, 0, 0, 0, 0, 0, 0, 32'h1234};
    vecs[7]  = '{0, 0, 0,            0, 0, 0,        0, 0, 7, 3, 0, 0, 1, 0, 0, 0, 32'h1234};
    // req1 commits to x7. Busy stays high while rd_we is high, then clears.
    vecs[8]  = '{0, 0, 0,            1, 7, 32'h77,   0, 0, 7, 0, 0, 1, 1, 0, 1, 7, 32'h77};
    vecs[9]  = '{0, 0, 0,            0, 0, 0,        0, 0, 7, 7, 0, 0, 1, 1, 0, 7, 32'h77};
    vecs[10] = '{0, 0, 0,            0, 0, 0,        0, 0, 7, 0, 0, 0, 0, 0, 0, 7, 32'h77};
    // x9: a new set lands on the same edge as the commit, and the set wins.
    vecs[11] = '{0, 0, 0,            1, 9, 32'h99,   1, 9, 9, 0, 0, 1, 0, 0, 1, 9, 32'h99};
    vecs[12] = '{0, 0, 0,            0, 0, 0,        1, 9, 9, 0, 0, 0, 1, 0, 0, 9, 32'h99};
    vecs[13] = '{0, 0, 0,            0, 0, 0,        0, 0, 9, 9, 0, 0, 1, 1, 0, 9, 32'h99};
    // An ALU write to x9 clears the pending bit (last writer clears).
    vecs[14] = '{1, 9, 32'hA9,       0, 0, 0,        0, 0, 9, 0, 1, 0, 1, 0, 1, 9, 32'hA9};
    vecs[15] = '{0, 0, 0,            0, 0, 0,        0, 0, 9, 0, 0, 0, 1, 0, 0, 9, 32'hA9};
    // A pend_set to x0 is ignored. x0 never reports busy.
    vecs[16] = '{0, 0, 0,            0, 0, 0,        1, 0, 9, 0, 0, 0, 0, 0, 0, 9, 32'hA9};
    // Idle cycles kept the pointer at req0, so a contested cycle goes to req1.
    vecs[17] = '{1, 1, 32'h11,       1, 2, 32'h22,   0, 0, 0, 0, 0, 1, 0, 0, 1, 2, 32'h22};

    // Reset with both requesters offering: nothing is granted or written.
    idleInputs();
    reset      = 1'b1;
    req0_valid = 1'b1;
    req0_addr  = 5'd6;
    req0_data  = 32'h66;
    req1_valid = 1'b1;
    req1_addr  = 5'd8;
    req1_data  = 32'h88;
    @(negedge clk);
    #1;
    checkOutput("reset req0_ready", 32'(req0_ready), 32'd0);
    checkOutput("reset req1_ready", 32'(req1_ready), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("reset rd_we", 32'(rd_we), 32'd0);
    checkOutput("reset rd_addr", 32'(rd_addr), 32'd0);
    checkOutput("reset rd_data", 32'(rd_data), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idleInputs();

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(i, vecs[i]);
    end

    // Reset in the middle of operation. Mark x3 pending while req0 writes x4.
    // The pointer is at req1 after the last vector, so the lone req0 is granted.
    @(negedge clk);
    idleInputs();
    pend_set      = 1'b1;
    pend_set_addr = 5'd3;
    req0_valid    = 1'b1;
    req0_addr     = 5'd4;
    req0_data     = 32'h44;
    rs1_addr      = 5'd3;
    #1;
    checkOutput("mid req0_ready pre", 32'(req0_ready), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("mid rs1_busy set", 32'(rs1_busy), 32'd1);
    checkOutput("mid rd_we pre", 32'(rd_we), 32'd1);
    // Pulse reset for one cycle with req0 still held valid.
    @(negedge clk);
    pend_set = 1'b0;
    reset    = 1'b1;
    #1;
    checkOutput("mid req0_ready reset", 32'(req0_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("mid rd_we reset", 32'(rd_we), 32'd0);
    checkOutput("mid rd_addr reset", 32'(rd_addr), 32'd0);
    checkOutput("mid rs1_busy reset", 32'(rs1_busy), 32'd0);
    // Release reset. The held request is granted again.
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("mid req0_ready resume", 32'(req0_ready), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("mid rd_we resume", 32'(rd_we), 32'd1);
    checkOutput("mid rd_addr resume", 32'(rd_addr), 32'd4);
    checkOutput("mid rd_data resume", 32'(rd_data), 32'h44);
    checkOutput("mid rs1_busy resume", 32'(rs1_busy), 32'd0);

    @(negedge clk);
    idleInputs();
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
